// File: rtl/soc_sysid_pkg.sv
// Shared register map, CTRL bit positions and CAPS layout for the system-ID block.
package soc_sysid_pkg;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_TSTAMP  = 3'd1;
    localparam logic [2:0] REG_UP_LO   = 3'd2;
    localparam logic [2:0] REG_UP_HI   = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_CAPS    = 3'd6;

    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam int CAPS_CNT_W_LSB  = 0;
    localparam int CAPS_CNT_W_BITS = 8;

    function automatic logic [31:0] caps_word(input int cnt_w);
        logic [31:0] w;
        w = '0;
        w[CAPS_CNT_W_LSB +: CAPS_CNT_W_BITS] = 8'(cnt_w);
        return w;
    endfunction

endpackage

// File: rtl/soc_sysid_uptime.sv
// Free-running uptime counter with freeze/clear and the UP_HI snapshot register.
module soc_sysid_uptime
    import soc_sysid_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        freeze,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snap_hi
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      hi_ext;
    logic [31:0]      snap_reg;

    // Clear wins over increment; wrap past all-ones is plain modular arithmetic.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (!freeze) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_comb begin
        hi_ext = '0;
        hi_ext[HI_W-1:0] = count_reg[CNT_W-1:32];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            snap_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (snap) begin
                snap_reg <= hi_ext;
            end
        end
    end

    assign count_lo = count_reg[31:0];
    assign snap_hi  = snap_reg;

endmodule

// File: rtl/soc_sysid_ext.sv
// Avalon-MM system-ID peripheral: ID/timestamp words, uptime counter, scratch and control.
module soc_sysid_ext
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h61E5_8B43,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int          CNT_W     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic        wr_en;
    logic        ctrl_wr;
    logic        clear;
    logic        snap;
    logic        freeze_reg;
    logic [31:0] scratch_reg;
    logic [31:0] readdata_reg;
    logic        readdatavalid_reg;
    logic [31:0] rd_mux;
    logic [31:0] up_lo;
    logic [31:0] up_hi;

    // A simultaneous read takes the slot; the write is dropped.
    assign wr_en   = write & ~read;
    assign ctrl_wr = wr_en && (address == REG_CTRL) && byteenable[0];
    assign clear   = ctrl_wr && writedata[CTRL_CLEAR_BIT];
    assign snap    = read && (address == REG_UP_LO);

    soc_sysid_uptime #(
        .CNT_W (CNT_W)
    ) u_uptime (
        .clock    (clock),
        .reset_n  (reset_n),
        .freeze   (freeze_reg),
        .clear    (clear),
        .snap     (snap),
        .count_lo (up_lo),
        .snap_hi  (up_hi)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch_lane
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                scratch_reg[gi*8 +: 8] <= '0;
            end else if (wr_en && (address == REG_SCRATCH) && byteenable[gi]) begin
                scratch_reg[gi*8 +: 8] <= writedata[gi*8 +: 8];
            end
        end
    end

    // A clear command leaves freeze as it was, so a frozen counter can be zeroed and held there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freeze_reg <= 1'b0;
        end else if (ctrl_wr && !writedata[CTRL_CLEAR_BIT]) begin
            freeze_reg <= writedata[CTRL_FREEZE_BIT];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_ID:      rd_mux = SYSTEM_ID;
            REG_TSTAMP:  rd_mux = TIMESTAMP;
            REG_UP_LO:   rd_mux = up_lo;
            REG_UP_HI:   rd_mux = up_hi;
            REG_SCRATCH: rd_mux = scratch_reg;
            REG_CTRL:    rd_mux[CTRL_FREEZE_BIT] = freeze_reg;
            REG_CAPS:    rd_mux = caps_word(CNT_W);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            readdatavalid_reg <= read;
            if (read) begin
                readdata_reg <= rd_mux;
            end
        end
    end

    assign readdata      = readdata_reg;
    assign readdatavalid = readdatavalid_reg;

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Directed and randomized checks of soc_sysid_ext against a behavioural register-map model.
module tb_soc_sysid_ext;

    localparam int          CNT_W = 40;
    localparam logic [31:0] SYSID = 32'h61E5_8B43;
    localparam logic [31:0] TSTMP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks = 0;
    int failures = 0;

    // Model state: the counter is an integer taken modulo 2^CNT_W.
    longint unsigned m_cnt;
    bit              m_freeze;
    logic [31:0]     m_scratch;
    logic [31:0]     m_snap;
    logic [31:0]     m_rdata;
    logic            m_valid;

    soc_sysid_ext #(
        .SYSTEM_ID (SYSID),
        .TIMESTAMP (TSTMP),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return SYSID;
            3'd1:    return TSTMP;
            3'd2:    return m_cnt[31:0];
            3'd3:    return m_snap;
            3'd4:    return m_scratch;
            3'd5:    return {31'd0, m_freeze};
            3'd6:    return 32'(CNT_W);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_freeze = 0; m_scratch = '0; m_snap = '0; m_rdata = '0; m_valid = 1'b0;
    endtask

    // One bus cycle: drive at the falling edge, advance the model at the rising edge, check 1 ns later.
    task automatic step(input string tag, input logic [2:0] a, input logic rd, input logic wr,
                        input logic [31:0] data, input logic [3:0] be, output logic [31:0] got);
        bit clr;
        bit f0;
        address = a; read = rd; write = wr; writedata = data; byteenable = be;
        @(posedge clock);
        f0 = m_freeze;
        clr = 0;
        m_valid = rd;
        if (rd) m_rdata = model_read(a);
        if (rd && a == 3'd2) m_snap = 32'(m_cnt >> 32);
        if (wr && !rd) begin
            if (a == 3'd4) begin
                for (int l = 0; l < 4; l++) if (be[l]) m_scratch[l*8 +: 8] = data[l*8 +: 8];
            end else if (a == 3'd5 && be[0]) begin
                if (data[1]) clr = 1; else m_freeze = data[0];
            end
        end
        if (clr) m_cnt = 0;
        else if (!f0) m_cnt = (m_cnt + 1) % (64'd1 << CNT_W);
        #1;
        check({tag, ".valid"}, {31'd0, readdatavalid}, {31'd0, m_valid});
        check({tag, ".data"}, readdata, m_rdata);
        got = readdata;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] v1;
        logic [31:0] v2;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset.valid", {31'd0, readdatavalid}, 32'd0);
        check("reset.data", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // ID and timestamp, then the valid pulse must be one cycle wide
        step("rd_id", 3'd0, 1, 0, 0, 0, got);
        step("rd_ts", 3'd1, 1, 0, 0, 0, got);
        step("idle_after_ts", 3'd0, 0, 0, 0, 0, got);
        step("rd_caps", 3'd6, 1, 0, 0, 0, got);

        // Byte-lane writes to SCRATCH
        step("wr_scr0", 3'd4, 0, 1, 32'h0, 4'hF, got);
        step("wr_scr1", 3'd4, 0, 1, 32'hAABB_CCDD, 4'b0101, got);
        step("rd_scr", 3'd4, 1, 0, 0, 0, got);
        step("wr_ro", 3'd0, 0, 1, 32'hFFFF_FFFF, 4'hF, got);
        step("rd_id2", 3'd0, 1, 0, 0, 0, got);
        step("rdwr_scr", 3'd4, 1, 1, 32'h1234_5678, 4'hF, got);
        step("rd_scr2", 3'd4, 1, 0, 0, 0, got);

        // Freeze: two UP_LO reads must match
        step("freeze", 3'd5, 0, 1, 32'h1, 4'h1, got);
        for (int i = 0; i < 10; i++) step("frz_idle", 3'd0, 0, 0, 0, 0, got);
        step("frz_rd1", 3'd2, 1, 0, 0, 0, v1);
        step("frz_rd2", 3'd2, 1, 0, 0, 0, v2);
        check("frz_equal", v2, v1);
        step("clear_frz", 3'd5, 0, 1, 32'h2, 4'h1, got);
        step("clr_rd", 3'd2, 1, 0, 0, 0, got);
        check("clr_small", {31'd0, got < 32'd4}, 32'd1);
        step("rd_ctrl", 3'd5, 1, 0, 0, 0, got);

        // Unfreeze; UP_LO read immediately before a clear returns the old value, next read starts from 0
        step("unfreeze", 3'd5, 0, 1, 32'h0, 4'h1, got);
        for (int i = 0; i < 5; i++) step("run_idle", 3'd7, 0, 0, 0, 0, got);
        step("pre_clr_rd", 3'd2, 1, 0, 0, 0, got);
        step("clear_run", 3'd5, 0, 1, 32'h2, 4'h1, got);
        step("post_clr_rd", 3'd2, 1, 0, 0, 0, got);
        check("post_clr_zero", got, 32'd0);

        // Preload the counter to 2^32-1 to exercise the carry into the snapshot
        force dut.u_uptime.count_reg = 40'h00_FFFF_FFFF;
        release dut.u_uptime.count_reg;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        step("carry_lo", 3'd2, 1, 0, 0, 0, got);
        check("carry_lo_ones", got, 32'hFFFF_FFFF);
        step("carry_hi", 3'd3, 1, 0, 0, 0, got);
        check("carry_hi_zero", got, 32'd0);
        step("carry_lo2", 3'd2, 1, 0, 0, 0, got);
        step("carry_hi2", 3'd3, 1, 0, 0, 0, got);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 4'($urandom_range(0, 15)), got);
        end

        // Make SCRATCH non-zero, then reset in the middle of a read
        step("pre_rst_wr", 3'd4, 0, 1, 32'hDEAD_BEEF, 4'hF, got);
        step("pre_rst_rd", 3'd0, 1, 0, 0, 0, got);
        address = 3'd4; read = 1'b1;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_async.valid", {31'd0, readdatavalid}, 32'd0);
        check("rst_async.data", readdata, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_hold.valid", {31'd0, readdatavalid}, 32'd0);
        @(negedge clock);
        read = 1'b0;
        reset_n = 1'b1;
        step("rd_uplo_first", 3'd2, 1, 0, 0, 0, got);
        step("rd_uphi_rst", 3'd3, 1, 0, 0, 0, got);
        step("rd_scr_rst", 3'd4, 1, 0, 0, 0, got);
        step("rd_ctrl_rst", 3'd5, 1, 0, 0, 0, got);
        step("rd_caps_rst", 3'd6, 1, 0, 0, 0, got);
        check("caps_cntw", got, 32'd40);
        step("rd_unmapped", 3'd7, 1, 0, 0, 0, got);
        step("final_idle", 3'd0, 0, 0, 0, 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
